// File: rtl/gb_cpu_fetch_unit.sv
// Game Boy CPU fetch unit: owns the PC, fetches opcode bytes, tracks the CB prefix
// and turns pending interrupts into ISR commands for the decoder.
module gb_cpu_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        fetch_req,
  input  logic        cb_next,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic        halt_req,
  input  logic        ime,
  input  logic [4:0]  int_enable,
  input  logic [4:0]  int_flag,
  output logic [7:0]  opcode,
  output logic        cb_prefix,
  output logic        isr_cmd,
  output logic        instr_valid,
  output logic [15:0] isr_vector,
  output logic [4:0]  int_ack,
  output logic [15:0] pc,
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, WAIT, IDLE, HALT} state_t;

  state_t      state, state_nxt;
  logic        pending_cb;
  logic        take_isr, set_cb, clr_cb;
  logic [4:0]  int_pend;
  logic        int_any;
  logic [2:0]  int_k;

  // Lowest set bit wins: VBlank has the highest interrupt priority.
  function automatic logic [2:0] lowest_bit(input logic [4:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign int_pend = int_enable & int_flag;
  assign int_any  = |int_pend;
  assign int_k    = lowest_bit(int_pend);

  assign mem_rd   = (state == FETCH) && !reset;
  assign mem_addr = mem_rd ? pc : 16'h0000;
  assign halted   = (state == HALT);

  always_comb begin
    state_nxt = state;
    take_isr  = 1'b0;
    set_cb    = 1'b0;
    clr_cb    = 1'b0;
    case (state)
      FETCH: state_nxt = WAIT;
      WAIT:  state_nxt = IDLE;
      IDLE: begin
        if (fetch_req) begin
          if (halt_req) begin
            state_nxt = HALT;
            clr_cb    = 1'b1;
          end else if (cb_next) begin
            // Prefix and suffix are never split by an interrupt.
            state_nxt = FETCH;
            set_cb    = 1'b1;
          end else if (ime && int_any) begin
            take_isr  = 1'b1;
            clr_cb    = 1'b1;
          end else begin
            state_nxt = FETCH;
            clr_cb    = 1'b1;
          end
        end
      end
      HALT: begin
        if (int_any) begin
          clr_cb = 1'b1;
          if (ime) begin
            take_isr  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      pending_cb  <= 1'b0;
      opcode      <= 8'h00;
      cb_prefix   <= 1'b0;
      isr_cmd     <= 1'b0;
      instr_valid <= 1'b0;
      isr_vector  <= 16'h0000;
      int_ack     <= 5'h00;
    end else begin
      state       <= state_nxt;
      instr_valid <= 1'b0;
      int_ack     <= 5'h00;

      if (pc_load)
        pc <= pc_load_value;
      else if (state == FETCH)
        pc <= pc + 16'h0001;

      if (set_cb)
        pending_cb <= 1'b1;
      else if (clr_cb)
        pending_cb <= 1'b0;

      if (state == WAIT) begin
        opcode      <= mem_rdata;
        cb_prefix   <= pending_cb;
        isr_cmd     <= 1'b0;
        instr_valid <= 1'b1;
      end

      if (take_isr) begin
        opcode      <= 8'h00;
        cb_prefix   <= 1'b0;
        isr_cmd     <= 1'b1;
        instr_valid <= 1'b1;
        isr_vector  <= 16'h0040 + {10'b0, int_k, 3'b000};
        int_ack     <= 5'(5'b00001 << int_k);
      end
    end
  end

endmodule

// File: tb/tb_gb_cpu_fetch_unit.sv
// Directed bench for gb_cpu_fetch_unit with a one-cycle-latency byte memory model.
module tb_gb_cpu_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        fetch_req, cb_next, pc_load, halt_req, ime;
  logic [15:0] pc_load_value;
  logic [4:0]  int_enable, int_flag;
  logic [7:0]  opcode;
  logic        cb_prefix, isr_cmd, instr_valid, halted;
  logic [15:0] isr_vector, pc;
  logic [4:0]  int_ack;

  logic [7:0]  mem [0:65535];
  int          n_checks = 0;
  int          n_fail = 0;

  gb_cpu_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .fetch_req(fetch_req), .cb_next(cb_next),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .halt_req(halt_req),
    .ime(ime), .int_enable(int_enable), .int_flag(int_flag), .opcode(opcode),
    .cb_prefix(cb_prefix), .isr_cmd(isr_cmd), .instr_valid(instr_valid),
    .isr_vector(isr_vector), .int_ack(int_ack), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h3E;
    mem[16'h0001] = 8'hCB;
    mem[16'h0002] = 8'h37;
    mem[16'h0003] = 8'h76;
    mem[16'hFFFF] = 8'hC3;
    mem[16'h1234] = 8'hAF;

    reset = 1'b1; fetch_req = 0; cb_next = 0; pc_load = 0; halt_req = 0; ime = 0;
    pc_load_value = 16'h0000; int_enable = 5'h00; int_flag = 5'h00;
    step(); step();
    check_eq("rst_mem_rd", 16'(mem_rd), 16'h0);
    check_eq("rst_pc", pc, 16'h0000);
    check_eq("rst_opcode", 16'(opcode), 16'h00);
    check_eq("rst_valid", 16'(instr_valid), 16'h0);
    check_eq("rst_isr", {11'b0, int_ack}, 16'h0);
    check_eq("rst_halted", 16'(halted), 16'h0);

    // Automatic first fetch after reset release
    reset = 1'b0;
    #1;
    check_eq("boot_mem_rd", 16'(mem_rd), 16'h1);
    check_eq("boot_addr", mem_addr, 16'h0000);
    step();
    check_eq("boot_pc", pc, 16'h0001);
    check_eq("boot_wait_valid", 16'(instr_valid), 16'h0);
    step();
    check_eq("boot_opcode", 16'(opcode), 16'h003E);
    check_eq("boot_valid", 16'(instr_valid), 16'h1);

    // Fetch the CB prefix byte
    fetch_req = 1;
    step();
    fetch_req = 0;
    check_eq("cb_fetch_addr", mem_addr, 16'h0001);
    step(); step();
    check_eq("cb_opcode", 16'(opcode), 16'h00CB);
    check_eq("cb_first_prefix", 16'(cb_prefix), 16'h0);

    // cb_next with a pending, enabled interrupt must still fetch the suffix
    ime = 1; int_enable = 5'h01; int_flag = 5'h01; fetch_req = 1; cb_next = 1;
    step();
    fetch_req = 0; cb_next = 0;
    check_eq("cb_suffix_rd", 16'(mem_rd), 16'h1);
    check_eq("cb_suffix_addr", mem_addr, 16'h0002);
    check_eq("cb_no_isr", {11'b0, int_ack}, 16'h0);
    step(); step();
    check_eq("cb_suffix_op", 16'(opcode), 16'h0037);
    check_eq("cb_suffix_pfx", 16'(cb_prefix), 16'h1);
    check_eq("cb_suffix_ack", {11'b0, int_ack}, 16'h0);

    fetch_req = 1;
    step();
    fetch_req = 0;
    check_eq("isr0_cmd", 16'(isr_cmd), 16'h1);
    check_eq("isr0_valid", 16'(instr_valid), 16'h1);
    check_eq("isr0_vector", isr_vector, 16'h0040);
    check_eq("isr0_ack", {11'b0, int_ack}, 16'h0001);
    check_eq("isr0_opcode", 16'(opcode), 16'h0000);
    check_eq("isr0_pfx", 16'(cb_prefix), 16'h0);
    check_eq("isr0_no_rd", 16'(mem_rd), 16'h0);
    check_eq("isr0_pc", pc, 16'h0003);
    step();
    check_eq("isr0_ack_pulse", {11'b0, int_ack}, 16'h0);
    check_eq("isr0_cmd_hold", 16'(isr_cmd), 16'h1);

    // Priority: IF=14 under IE=1F selects bit 2
    int_enable = 5'h1F; int_flag = 5'h14; fetch_req = 1;
    step();
    fetch_req = 0;
    check_eq("isr2_vector", isr_vector, 16'h0050);
    check_eq("isr2_ack", {11'b0, int_ack}, 16'h0004);
    check_eq("isr2_no_rd", 16'(mem_rd), 16'h0);
    check_eq("isr2_pc", pc, 16'h0003);

    // HALT, then wake with ime=0
    ime = 0; int_enable = 5'h00; int_flag = 5'h00; fetch_req = 1; halt_req = 1;
    step();
    fetch_req = 0; halt_req = 0;
    check_eq("halt_on", 16'(halted), 16'h1);
    step();
    check_eq("halt_hold", 16'(halted), 16'h1);
    check_eq("halt_no_rd", 16'(mem_rd), 16'h0);
    int_enable = 5'h08; int_flag = 5'h08;
    step();
    check_eq("wake_halted", 16'(halted), 16'h0);
    check_eq("wake_rd", 16'(mem_rd), 16'h1);
    check_eq("wake_addr", mem_addr, 16'h0003);
    check_eq("wake_ack", {11'b0, int_ack}, 16'h0);
    int_enable = 5'h00; int_flag = 5'h00;
    step(); step();
    check_eq("wake_opcode", 16'(opcode), 16'h0076);
    check_eq("wake_isr_clear", 16'(isr_cmd), 16'h0);
    check_eq("wake_pfx", 16'(cb_prefix), 16'h0);

    // PC wrap at FFFF
    pc_load = 1; pc_load_value = 16'hFFFF; fetch_req = 1;
    step();
    pc_load = 0; fetch_req = 0;
    check_eq("wrap_addr", mem_addr, 16'hFFFF);
    step();
    check_eq("wrap_pc", pc, 16'h0000);
    step();
    check_eq("wrap_opcode", 16'(opcode), 16'h00C3);

    // pc_load during FETCH wins over the increment, fetch uses old pc
    pc_load = 1; pc_load_value = 16'hFFFF; fetch_req = 1;
    step();
    fetch_req = 0; pc_load_value = 16'h1234;
    check_eq("load_fetch_addr", mem_addr, 16'hFFFF);
    step();
    pc_load = 0;
    check_eq("load_wins_pc", pc, 16'h1234);
    step();
    fetch_req = 1;
    step();
    fetch_req = 0;
    check_eq("load_next_addr", mem_addr, 16'h1234);
    step();

    // Reset in WAIT clears everything immediately
    reset = 1'b1;
    #1;
    check_eq("midrst_opcode", 16'(opcode), 16'h00);
    check_eq("midrst_valid", 16'(instr_valid), 16'h0);
    check_eq("midrst_pc", pc, 16'h0000);
    check_eq("midrst_rd", 16'(mem_rd), 16'h0);
    step();
    reset = 1'b0;
    #1;
    check_eq("refetch_addr", mem_addr, 16'h0000);
    check_eq("refetch_rd", 16'(mem_rd), 16'h1);
    step(); step();
    check_eq("refetch_opcode", 16'(opcode), 16'h003E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
